shift_right_seq: RTL and testbench

Sequential right shifter, the counterpart to the team's combinational one-place left shifter. It moves an operand toward the LSB one bit per clock for a requested count. A start/busy/done handshake sits it beside the ALU datapath. The fill policy is logical, arithmetic, rotate or serial-in, and the last bit shifted out of the LSB is reported on `cout`.

---
 rtl/shift_right_seq.sv | 134 +++++++++++++
 tb/tb_shift_right_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// shift_right_seq: sequential right shifter, one bit position per clock.
// A start/busy/done handshake wraps a shift register whose fill bit is
// chosen per operation: logical (0), arithmetic (MSB), rotate (LSB) or
// serial-in (live sin). cout reports the last bit shifted out of the LSB.
module shift_right_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] f_r;
    logic [WIDTH-1:0] f_next_s;
    logic             cout_r;
    logic             cout_next_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_next_s;
    logic [AMT_W-1:0] amt_sat_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_next_s;
    logic             fill_s;
    logic             busy_r;
    logic             done_r;

    // Clamp the requested count to WIDTH; more shifts would change nothing useful.
    always_comb begin
        amt_sat_s = amt;
        if (amt > AMT_W'(WIDTH)) begin
            amt_sat_s = AMT_W'(WIDTH);
        end else begin
            amt_sat_s = amt;
        end
    end

    // Select the bit entering at the MSB from the latched mode.
    always_comb begin
        fill_s = 1'b0;
        case (mode_r)
            2'b00:   fill_s = 1'b0;
            2'b01:   fill_s = f_r[WIDTH-1];
            2'b10:   fill_s = f_r[0];
            2'b11:   fill_s = sin;
            default: fill_s = 1'b0;
        endcase
    end

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        next_state_s = state_r;
        f_next_s     = f_r;
        cout_next_s  = cout_r;
        cnt_next_s   = cnt_r;
        mode_next_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    f_next_s    = x;
                    cout_next_s = 1'b0;
                    mode_next_s = mode;
                    cnt_next_s  = amt_sat_s;
                    if (amt_sat_s != {AMT_W{1'b0}}) begin
                        next_state_s = ST_SHIFT;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                cout_next_s = f_r[0];
                f_next_s    = {fill_s, f_r[WIDTH-1:1]};
                cnt_next_s  = cnt_r - AMT_W'(1);
                if (cnt_r == AMT_W'(1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done are registered from the next state
    // so they line up with the state they describe without any input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            f_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            cnt_r   <= {AMT_W{1'b0}};
            mode_r  <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            f_r     <= f_next_s;
            cout_r  <= cout_next_s;
            cnt_r   <= cnt_next_s;
            mode_r  <= mode_next_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    assign f    = f_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases from the block's
// behaviour description followed by randomized operations, all compared
// against an arithmetic reference model.
module tb_shift_right_seq;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  x;
    logic [AW-1:0] amt;
    logic [1:0]    mode;
    logic          sin;
    logic [W-1:0]  f;
    logic          cout;
    logic          busy;
    logic          done;

    int n_cmp;
    int n_err;

    shift_right_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .amt   (amt),
        .mode  (mode),
        .sin   (sin),
        .f     (f),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result of n right shifts computed directly from the rules.
    task automatic model(input logic [W-1:0] xv, input int n, input logic [1:0] mv,
                         input logic [15:0] sb, output logic [W-1:0] ef, output logic ec);
        case (mv)
            2'b00: ef = xv >> n;
            2'b01: ef = $signed(xv) >>> n;
            2'b10: ef = (xv >> n) | (xv << (W - n));
            default: begin
                ef = xv >> n;
                for (int i = 0; i < n; i++) ef[W - n + i] = sb[i];
            end
        endcase
        if (n == 0) ec = 1'b0;
        else if (mv == 2'b10) ec = xv[(n - 1) % W];
        else ec = xv[n - 1];
    endtask

    // One full operation: issue, track shifts, check done/result/hold.
    task automatic do_op(input string tag, input logic [W-1:0] xv, input logic [AW-1:0] av,
                         input logic [1:0] mv, input logic [15:0] sb, input bit hold);
        int n;
        int c;
        logic [W-1:0] ef;
        logic ec;
        n = (int'(av) > W) ? W : int'(av);
        model(xv, n, mv, sb, ef, ec);
        @(negedge clk);
        start = 1'b1; x = xv; amt = av; mode = mv; sin = sb[0];
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        x = W'($urandom); amt = AW'($urandom); mode = 2'($urandom);
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        c = 0;
        while (!done && c < 40) begin
            sin = sb[c % 16];
            @(posedge clk); #1;
            c++;
            if (!done) check({tag, "_busy_mid"}, 32'(busy), 32'd1);
        end
        check({tag, "_latency"}, 32'(c), 32'(n));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_f"}, 32'(f), 32'(ef));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_f_hold"}, 32'(f), 32'(ef));
        check({tag, "_cout_hold"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        int saw_done;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; x = '0; amt = '0; mode = 2'b00; sin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_f", 32'(f), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op("log1",   8'h81, 4'd1, 2'b00, 16'h0000, 1'b0);
        do_op("ari3",   8'h80, 4'd3, 2'b01, 16'h0000, 1'b0);
        do_op("ari9",   8'h80, 4'd9, 2'b01, 16'h0000, 1'b0);
        do_op("rot1",   8'h01, 4'd1, 2'b10, 16'h0000, 1'b0);
        do_op("rot8",   8'h01, 4'd8, 2'b10, 16'h0000, 1'b0);
        do_op("rot4",   8'h81, 4'd4, 2'b10, 16'h0000, 1'b0);
        do_op("sin4",   8'h00, 4'd4, 2'b11, 16'b1101, 1'b0);
        do_op("amt0",   8'h5A, 4'd0, 2'b00, 16'h0000, 1'b0);
        do_op("log15",  8'hC3, 4'd15, 2'b00, 16'h0000, 1'b0);
        do_op("hold5",  8'hB7, 4'd5, 2'b01, 16'h0000, 1'b1);

        // Reset in the middle of a six-shift operation.
        @(negedge clk);
        start = 1'b1; x = 8'hFF; amt = 4'd6; mode = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("abort_f", 32'(f), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        saw_done = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        do_op("post_rst", 8'h96, 4'd2, 2'b00, 16'h0000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_op("rand", W'($urandom), AW'($urandom), 2'($urandom),
                  16'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
